// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Purpose  : Writeback requester handshakes (A/B) and register-file write bus.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output wr_en, wr_addr, wr_data
  );

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter of two writeback requesters onto one
//            registered register-file write port, with a conflict counter.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  wire logic         clk,
  input  wire logic         clr,
  input  wire logic         hold,
  input  wire logic         cnt_clr,
  output logic [15:0]       conflict_cnt,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic        c_grant_a = 1'b0;
  localparam logic        c_grant_b = 1'b1;
  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic              last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;

  logic              w_a_win;
  logic              w_b_win;
  logic              w_accept;
  logic              w_both_valid;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  assign w_both_valid = bus.a_valid & bus.b_valid;

  // Grant decode: readys stay low in reset and while held.
  always_comb begin
    w_a_win = 1'b0;
    w_b_win = 1'b0;
    if (clr && !hold) begin
      if (w_both_valid) begin
        w_a_win = (last_grant_q == c_grant_b);
        w_b_win = (last_grant_q == c_grant_a);
      end else begin
        w_a_win = bus.a_valid;
        w_b_win = bus.b_valid;
      end
    end
  end

  assign w_accept   = w_a_win | w_b_win;
  assign w_sel_addr = w_b_win ? bus.b_addr : bus.a_addr;
  assign w_sel_data = w_b_win ? bus.b_data : bus.a_data;

  always_comb begin
    last_grant_d   = last_grant_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    conflict_cnt_d = conflict_cnt_q;

    if (w_a_win) begin
      last_grant_d = c_grant_a;
    end else if (w_b_win) begin
      last_grant_d = c_grant_b;
    end

    // Register 0 is hardwired: handshake completes but no write strobe.
    if (w_accept) begin
      wr_en_d   = (w_sel_addr != '0);
      wr_addr_d = w_sel_addr;
      wr_data_d = w_sel_data;
    end

    if (cnt_clr) begin
      conflict_cnt_d = '0;
    end else if (w_both_valid && (conflict_cnt_q != c_cnt_max)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      last_grant_q   <= c_grant_b;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.a_ready   = w_a_win;
  assign bus.b_ready   = w_b_win;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign conflict_cnt  = conflict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed stimulus with a write-port scoreboard for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic        hold;
  logic        cnt_clr;
  logic [15:0] conflict_cnt;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .clr          (clr),
    .hold         (hold),
    .cnt_clr      (cnt_clr),
    .conflict_cnt (conflict_cnt),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest expected write in its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.wr_en == 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: actual addr=%0h data=%0h cyc=%0d required no write",
                 bus.wr_addr, bus.wr_data, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.wr_addr !== e.addr || bus.wr_data !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL wr_data: actual addr=%0h data=%0h cyc=%0d required addr=%0h data=%0h cyc=%0d",
                   bus.wr_addr, bus.wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      checks++;
      failures++;
      e = sb.pop_front();
      $display("FAIL wr_missing: actual wr_en=0 cyc=%0d required addr=%0h data=%0h",
               cyc, e.addr, e.data);
    end
  end

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic h, input logic exp_ar, input logic exp_br,
                       input string name);
    exp_t e;
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    hold = h;
    @(negedge clk);
    check({name, " a_ready"}, {63'd0, bus.a_ready}, {63'd0, exp_ar});
    check({name, " b_ready"}, {63'd0, bus.b_ready}, {63'd0, exp_br});
    if (exp_ar && aa != 5'd0) begin
      e.addr = aa; e.data = ad; e.cyc = cyc + 1; sb.push_back(e);
    end else if (exp_br && ba != 5'd0) begin
      e.addr = ba; e.data = bd; e.cyc = cyc + 1; sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    hold = 1'b0;
  endtask

  task automatic check_outs(input string name, input logic en, input logic [4:0] addr,
                            input logic [31:0] data, input logic [15:0] cnt);
    @(negedge clk);
    check({name, " wr_en"}, {63'd0, bus.wr_en}, {63'd0, en});
    check({name, " wr_addr"}, {59'd0, bus.wr_addr}, {59'd0, addr});
    check({name, " wr_data"}, {32'd0, bus.wr_data}, {32'd0, data});
    check({name, " conflict_cnt"}, {48'd0, conflict_cnt}, {48'd0, cnt});
  endtask

  task automatic do_reset();
    idle();
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
  endtask

  initial begin
    clr = 1'b0; hold = 1'b0; cnt_clr = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    // Readys must stay low while in reset even with both requesters valid.
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b0, "in_reset");
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b0, "in_reset2");
    idle();
    clr = 1'b1;
    check_outs("after_reset", 1'b0, 5'd0, 32'd0, 16'd0);
    @(posedge clk); #1;

    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, "a_only");
    idle();
    check_outs("a_only_wr", 1'b1, 5'd5, 32'hDEAD_BEEF, 16'd0);
    @(posedge clk); #1;

    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + i, 1'b0,
            (i % 2) == 0, (i % 2) == 1, "contend");
    end
    idle();
    check_outs("contend_end", 1'b1, 5'd2, 32'h203, 16'd4);
    @(posedge clk); #1;

    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd7, 1'b0, 1'b0, 1'b1, "b_addr0");
    idle();
    check_outs("b_addr0_wr", 1'b0, 5'd0, 32'd7, 16'd4);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, "hold");
    end
    drive(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, "hold_release");
    idle();

    // Last grant was A, so B wins the same-address race, then A overwrites.
    drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB, 1'b0, 1'b0, 1'b1, "same_addr_b");
    drive(1'b1, 5'd3, 32'hAAAA, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, "same_addr_a");
    idle();
    check_outs("same_addr_end", 1'b1, 5'd3, 32'hAAAA, 16'd5);
    @(posedge clk); #1;

    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, "pre_clr");
    clr = 1'b0;
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 1'b0, "clr_inflight");
    clr = 1'b1;
    idle();
    check_outs("clr_outs", 1'b0, 5'd0, 32'd0, 16'd0);
    @(posedge clk); #1;

    bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'h1;
    bus.b_valid = 1'b1; bus.b_addr = 5'd2; bus.b_data = 32'h2;
    hold = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check_outs("sat_fffe", 1'b0, 5'd0, 32'd0, 16'hFFFE);
    @(posedge clk); #1;
    check_outs("sat_ffff", 1'b0, 5'd0, 32'd0, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check_outs("sat_hold", 1'b0, 5'd0, 32'd0, 16'hFFFF);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check_outs("cnt_clr", 1'b0, 5'd0, 32'd0, 16'd0);
    idle();
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of write data.
REQ-002 SHALL have parameter ADDR_W, default 5, width of register address.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port clr, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have ports a_valid/a_ready/a_addr/a_data, in/out/in/in, 1/1/ADDR_W/DATA_W, requester A (ALU writeback) handshake.
REQ-006 SHALL have ports b_valid/b_ready/b_addr/b_data, in/out/in/in, 1/1/ADDR_W/DATA_W, requester B (load writeback) handshake.
REQ-007 SHALL have port hold, input, 1, stalls all grants while high.
REQ-008 SHALL have ports wr_en/wr_addr/wr_data, output, 1/ADDR_W/DATA_W, registered drive to register-file write_cntrl/writeaddr/write_data.
REQ-009 SHALL have port conflict_cnt, output, 16, saturating count of cycles with both requesters valid.
REQ-010 SHALL have port cnt_clr, input, 1, synchronous clear of conflict_cnt.

Function
REQ-011 SHALL complete a transfer on a requester in a cycle where its valid and ready are both high.
REQ-012 SHALL drive a_ready/b_ready combinationally from valids, hold and last_grant; at most one ready high per cycle.
REQ-013 SHALL drive both readys low while hold=1; requesters keep valid/addr/data stable until accepted.
REQ-014 SHALL grant the sole valid requester when only one is valid and hold=0.
REQ-015 SHALL, when both valid and hold=0, grant the requester not recorded in last_grant (round-robin).
REQ-016 SHALL update last_grant to the granted requester on every accepted transfer; unchanged otherwise.
REQ-017 SHALL register the accepted addr/data into wr_addr/wr_data and set wr_en=1 on the next rising edge (latency 1 cycle).
REQ-018 SHALL set wr_en=0 in the cycle following any cycle with no accepted transfer; wr_addr/wr_data hold last values.
REQ-019 SHALL accept a transfer with addr=0 (handshake completes) but force wr_en=0 for it; register 0 is never written.
REQ-020 SHALL process same-address requests from A and B in grant order; later grant overwrites earlier in register file.
REQ-021 SHALL sustain one accepted transfer per cycle; under continuous contention A and B alternate every cycle.
REQ-022 SHALL increment conflict_cnt by 1 in each cycle with a_valid=b_valid=1, including hold cycles, saturating at 16'hFFFF.
REQ-023 SHALL give cnt_clr priority over increment: conflict_cnt=0 on next edge.
REQ-024 SHALL ignore a_addr/a_data/b_addr/b_data when the corresponding valid is low.

Reset
REQ-025 SHALL, when clr=0 at a rising edge, set wr_en=0, wr_addr=0, wr_data=0, conflict_cnt=0, last_grant=B (A wins first contention).
REQ-026 SHALL hold a_ready=b_ready=0 while clr=0; a request in flight when clr asserts is dropped, not written.
REQ-027 SHALL accept transfers from the first edge after clr returns high.

Verification
REQ-028 SHALL cover: A only, addr=5 data=32'hDEAD_BEEF -> a_ready=1 same cycle, next cycle wr_en=1 wr_addr=5 wr_data=32'hDEAD_BEEF.
REQ-029 SHALL cover: after reset A and B valid 4 cycles (addr 1,2) -> grants A,B,A,B; wr_addr sequence 1,2,1,2; conflict_cnt ends 4 (before requesters drop).
REQ-030 SHALL cover: B valid addr=0 data=7 -> b_ready=1, next cycle wr_en=0.
REQ-031 SHALL cover: hold=1 for 3 cycles with A valid -> a_ready=0, wr_en=0 throughout; hold=0 -> accepted, wr_en=1 one cycle later.
REQ-032 SHALL cover: clr=0 asserted while both valid -> next cycle all outputs 0, readys 0; conflict_cnt preset near 16'hFFFF saturates, cnt_clr=1 -> 0.
